note_sequencer: RTL and testbench

Parametrised record/playback note memory for the music device. It sits between the keyboard-to-note converter and the datapath's frequency/display logic. It supersedes the fixed 16-note control counter with a configurable depth, note/octave width, step duration, loop mode and rest code. Notes are captured one per strobe while idle. They are replayed in order, one step every `TICKS_PER_STEP` clocks, either once or looping.

---
 rtl/note_sequencer.sv | 138 +++++++++++++
 tb/tb_note_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Record/playback note memory: captures notes one per strobe while idle and
// replays them one step every TICKS_PER_STEP clocks, either once or looping.
//
// state  | meaning
// S_IDLE | recording allowed, outputs held at zero
// S_PLAY | presenting slot step_idx, tick counter running
module note_sequencer #(
  parameter int DEPTH = 16,
  parameter int NOTE_W = 4,
  parameter int OCT_W = 2,
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter logic [NOTE_W-1:0] REST_CODE = {NOTE_W{1'b1}},
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [OCT_W-1:0]  octave_in,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic              clear,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] note_out,
  output logic [OCT_W-1:0]  octave_out,
  output logic              note_active,
  output logic              playing,
  output logic [IW-1:0]     step_idx,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              step_done
);
  localparam int TW = $clog2(TICKS_PER_STEP);
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICKS_PER_STEP - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t            r_state;
  logic [NOTE_W-1:0] r_mem_note [DEPTH];
  logic [OCT_W-1:0]  r_mem_oct [DEPTH];
  logic [CW-1:0]     r_count;
  logic [IW-1:0]     r_step;
  logic [TW-1:0]     r_tick;
  logic [NOTE_W-1:0] r_note;
  logic [OCT_W-1:0]  r_oct;
  logic              r_active;

  logic              w_full;
  logic              w_tc;
  logic              w_last;
  logic              w_start;
  logic              w_wr;
  logic [IW-1:0]     w_next;
  logic [IW-1:0]     w_wr_idx;

  assign w_full   = (r_count == DEPTH_C);
  assign w_tc     = (r_state == S_PLAY) && (r_tick == '0);
  assign w_last   = ((CW'(r_step) + CW'(1)) == r_count);
  assign w_next   = w_last ? '0 : r_step + IW'(1);
  assign w_start  = (r_state == S_IDLE) && play_req && (r_count != '0);
  assign w_wr     = (r_state == S_IDLE) && !clear && !w_start && note_valid && !w_full;
  assign w_wr_idx = r_count[IW-1:0];

  // Note memory is deliberately not reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_note[w_wr_idx] <= note_in;
      r_mem_oct[w_wr_idx]  <= octave_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_step   <= '0;
      r_tick   <= '0;
      r_note   <= '0;
      r_oct    <= '0;
      r_active <= 1'b0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_step   <= '0;
      r_tick   <= '0;
      r_note   <= '0;
      r_oct    <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_PLAY;
            r_step   <= '0;
            r_tick   <= TICK_LOAD;
            r_note   <= r_mem_note[0];
            r_oct    <= r_mem_oct[0];
            r_active <= (r_mem_note[0] != REST_CODE);
          end else if (w_wr) begin
            r_count <= r_count + CW'(1);
          end
        end
        S_PLAY: begin
          if (stop_req || (w_tc && w_last && !loop_en)) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_tick   <= '0;
            r_note   <= '0;
            r_oct    <= '0;
            r_active <= 1'b0;
          end else if (w_tc) begin
            // w_next already wraps to slot 0, so looping adds no gap cycle
            r_tick   <= TICK_LOAD;
            r_step   <= w_next;
            r_note   <= r_mem_note[w_next];
            r_oct    <= r_mem_oct[w_next];
            r_active <= (r_mem_note[w_next] != REST_CODE);
          end else begin
            r_tick <= r_tick - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note_out    = r_note;
  assign octave_out  = r_oct;
  assign note_active = r_active;
  assign playing     = (r_state == S_PLAY);
  assign step_idx    = r_step;
  assign count       = r_count;
  assign full        = w_full;
  // An aborted step never reports completion, even on its last clock.
  assign step_done   = w_tc && !stop_req && !clear;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus random
// traffic, compared every cycle against an elapsed-time playback model.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int NOTE_W = 4;
  localparam int OCT_W = 2;
  localparam int T = 4;
  localparam int REST = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              note_valid = 1'b0;
  logic [NOTE_W-1:0] note_in = '0;
  logic [OCT_W-1:0]  octave_in = '0;
  logic              play_req = 1'b0;
  logic              stop_req = 1'b0;
  logic              clear = 1'b0;
  logic              loop_en = 1'b0;
  logic [NOTE_W-1:0] note_out;
  logic [OCT_W-1:0]  octave_out;
  logic              note_active;
  logic              playing;
  logic [1:0]        step_idx;
  logic [2:0]        count;
  logic              full;
  logic              step_done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: recorded notes as queues, playback position as elapsed cycles.
  int m_note[$];
  int m_oct[$];
  bit m_play = 0;
  int m_elapsed = 0;

  int obs_play_cycles;
  int obs_done;
  int obs_notes[$];
  int obs_steps[$];
  logic last_done;

  note_sequencer #(
    .DEPTH(DEPTH), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .TICKS_PER_STEP(T)
  ) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_in(note_in),
    .octave_in(octave_in), .play_req(play_req), .stop_req(stop_req),
    .clear(clear), .loop_en(loop_en), .note_out(note_out),
    .octave_out(octave_out), .note_active(note_active), .playing(playing),
    .step_idx(step_idx), .count(count), .full(full), .step_done(step_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int cnt;
    int stp;
    int en;
    int eo;
    bit ed;
    cnt = m_note.size();
    stp = 0;
    en = 0;
    eo = 0;
    ed = 0;
    if (m_play) begin
      stp = (m_elapsed / T) % cnt;
      en = m_note[stp];
      eo = m_oct[stp];
      ed = ((m_elapsed % T) == T - 1) && !stop_req && !clear;
    end
    check("playing", playing, m_play);
    check("note_out", note_out, en);
    check("octave_out", octave_out, eo);
    check("note_active", note_active, m_play && (en != REST));
    check("step_idx", step_idx, stp);
    check("count", count, cnt);
    check("full", full, cnt == DEPTH);
    check("step_done", step_done, ed);
  endtask

  task automatic model_edge();
    int cnt;
    cnt = m_note.size();
    if (clear) begin
      m_play = 0;
      m_note.delete();
      m_oct.delete();
    end else if (m_play) begin
      if (stop_req) m_play = 0;
      else if ((m_elapsed % T) == T - 1 && ((m_elapsed / T) % cnt) == cnt - 1 && !loop_en)
        m_play = 0;
      else m_elapsed++;
    end else if (play_req && cnt > 0) begin
      m_play = 1;
      m_elapsed = 0;
    end else if (note_valid && cnt < DEPTH) begin
      m_note.push_back(int'(note_in));
      m_oct.push_back(int'(octave_in));
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    last_done = step_done;
    if (playing) obs_play_cycles++;
    if (step_done) begin
      obs_done++;
      obs_notes.push_back(int'(note_out));
    end
    obs_steps.push_back(int'(step_idx));
    if (reset) model_edge();
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    play_req = 1'b0;
    stop_req = 1'b0;
    clear = 1'b0;
  endtask

  task automatic rec(input int n, input int o);
    note_valid = 1'b1;
    note_in = NOTE_W'(n);
    octave_in = OCT_W'(o);
    tick();
  endtask

  task automatic clear_stats();
    obs_play_cycles = 0;
    obs_done = 0;
    obs_notes.delete();
    obs_steps.delete();
  endtask

  initial begin
    int exp_steps[20];
    @(negedge clk);
    check_outputs();
    check("reset_count", count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Record and play once
    rec(3, 1);
    rec(5, 2);
    rec(15, 0);
    play_req = 1'b1;
    tick();
    clear_stats();
    repeat (14) tick();
    check("once_play_cycles", obs_play_cycles, 12);
    check("once_step_done", obs_done, 3);
    check("once_count", count, 3);
    if (obs_notes.size() == 3) begin
      check("once_note0", obs_notes[0], 3);
      check("once_note1", obs_notes[1], 5);
      check("once_note2", obs_notes[2], 15);
    end else check("once_notes_len", obs_notes.size(), 3);

    // Overflow
    clear = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) rec(i, i % 4);
    check("ovf_count", count, 4);
    check("ovf_full", full, 1);
    play_req = 1'b1;
    tick();
    clear_stats();
    repeat (18) tick();
    check("ovf_play_cycles", obs_play_cycles, 16);
    if (obs_notes.size() == 4) begin
      for (int i = 0; i < 4; i++) check("ovf_note", obs_notes[i], i + 1);
    end else check("ovf_notes_len", obs_notes.size(), 4);

    // Loop mode
    clear = 1'b1;
    tick();
    rec(7, 1);
    rec(15, 3);
    loop_en = 1'b1;
    play_req = 1'b1;
    tick();
    clear_stats();
    repeat (20) tick();
    for (int i = 0; i < 20; i++) exp_steps[i] = (i / 4) % 2;
    for (int i = 0; i < 20; i++) check("loop_step", obs_steps[i], exp_steps[i]);
    repeat (4) tick();
    loop_en = 1'b0;
    clear_stats();
    repeat (10) tick();
    check("loop_drop_cycles", obs_play_cycles, 8);
    check("loop_drop_playing", playing, 0);

    // Play with empty memory
    clear = 1'b1;
    tick();
    play_req = 1'b1;
    tick();
    repeat (2) tick();
    check("empty_playing", playing, 0);

    // clear and note_valid together
    rec(2, 2);
    clear = 1'b1;
    note_valid = 1'b1;
    note_in = 4'd9;
    tick();
    check("clear_wins_count", count, 0);

    // stop_req on a step boundary
    rec(4, 0);
    rec(6, 1);
    play_req = 1'b1;
    tick();
    repeat (3) tick();
    stop_req = 1'b1;
    tick();
    check("stop_step_done", last_done, 0);
    check("stop_playing", playing, 0);
    check("stop_count", count, 2);

    // Async reset mid-playback
    rec(8, 2);
    play_req = 1'b1;
    tick();
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_playing", playing, 0);
    check("arst_note", note_out, 0);
    check("arst_oct", octave_out, 0);
    check("arst_active", note_active, 0);
    check("arst_step", step_idx, 0);
    check("arst_done", step_done, 0);
    check("arst_count", count, 0);
    m_play = 0;
    m_note.delete();
    m_oct.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("arst_release_count", count, 0);

    // Random traffic
    loop_en = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      clear = ($urandom_range(0, 99) < 2);
      stop_req = ($urandom_range(0, 99) < 4);
      play_req = ($urandom_range(0, 99) < 12);
      note_valid = ($urandom_range(0, 99) < 40);
      note_in = NOTE_W'($urandom_range(0, 15));
      octave_in = OCT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) loop_en = ~loop_en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
